// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, screen bounds and target defaults
package game_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_INVULN  = 2'd1,
        ST_EXPLODE = 2'd2,
        ST_DEAD    = 2'd3
    } target_state_t;

    localparam int SCREEN_MAX_X       = 639;
    localparam int SCREEN_MAX_Y       = 479;
    localparam int DEF_LIVES          = 3;
    localparam int DEF_EXPLODE_FRAMES = 16;
    localparam int DEF_INVULN_FRAMES  = 60;

    // Widened by one bit so callers can compare against a 10+10 bit sum.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/shell_target_if.sv
// rtl/shell_target_if.sv - shell/target geometry and game status bundle
interface shell_target_if;
    logic [9:0] ShellX;
    logic [9:0] ShellY;
    logic [9:0] ShellS_X;
    logic [9:0] ShellS_Y;
    logic       shell_flying;
    logic [9:0] TargetX;
    logic [9:0] TargetY;
    logic [9:0] TargetS;
    logic       spawn;
    logic       shell_hit;
    logic       target_alive;
    logic       blink;
    logic [1:0] explode_frame;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output ShellX, ShellY, ShellS_X, ShellS_Y, shell_flying,
        output TargetX, TargetY, TargetS, spawn,
        input  shell_hit, target_alive, blink, explode_frame, lives, game_over
    );

    modport slave (
        input  ShellX, ShellY, ShellS_X, ShellS_Y, shell_flying,
        input  TargetX, TargetY, TargetS, spawn,
        output shell_hit, target_alive, blink, explode_frame, lives, game_over
    );
endinterface

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - strict axis-aligned box intersection from centres and half-extents
module box_overlap
    import game_pkg::*;
(
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] a_sx,
    input  logic [9:0] a_sy,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] b_sx,
    input  logic [9:0] b_sy,
    output logic       overlap
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] sum_x;
    logic [10:0] sum_y;

    // Touching edges (distance == sum) do not count as a collision.
    always_comb begin
        dx      = abs_diff(a_x, b_x);
        dy      = abs_diff(a_y, b_y);
        sum_x   = {1'b0, a_sx} + {1'b0, b_sx};
        sum_y   = {1'b0, a_sy} + {1'b0, b_sy};
        overlap = (dx < sum_x) && (dy < sum_y);
    end

endmodule

// File: rtl/shell_target.sv
// rtl/shell_target.sv - destructible target: hit detection, lives, explosion and respawn FSM
module shell_target
    import game_pkg::*;
#(
    parameter int LIVES          = DEF_LIVES,
    parameter int EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
    parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES
) (
    input  logic           frame_clk,
    input  logic           Reset,
    shell_target_if.slave  bus
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] EXP_LAST   = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0] INV_LAST   = 8'(INVULN_FRAMES - 1);

    target_state_t state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    lives_q, lives_d;
    logic          armed_q, armed_d;
    logic          shell_hit_q, shell_hit_d;
    logic          blink_q, blink_d;
    logic [1:0]    ef_q, ef_d;
    logic          game_over_q, game_over_d;
    logic          alive_q, alive_d;
    logic          overlap;
    logic          hit_cond;

    box_overlap u_overlap (
        .a_x     (bus.ShellX),
        .a_y     (bus.ShellY),
        .a_sx    (bus.ShellS_X),
        .a_sy    (bus.ShellS_Y),
        .b_x     (bus.TargetX),
        .b_y     (bus.TargetY),
        .b_sx    (bus.TargetS),
        .b_sy    (bus.TargetS),
        .overlap (overlap)
    );

    always_comb begin
        hit_cond    = bus.shell_flying && overlap && !armed_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        lives_d     = lives_q;
        shell_hit_d = hit_cond && (state_q == ST_ALIVE || state_q == ST_INVULN);
        // One shell in flight may only ever score once; landing re-arms.
        armed_d     = bus.shell_flying && (armed_q || shell_hit_d);

        case (state_q)
            ST_ALIVE: begin
                cnt_d = 8'd0;
                if (hit_cond) begin
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    state_d = ST_EXPLODE;
                end
            end
            ST_INVULN: begin
                if (cnt_q == INV_LAST) begin
                    state_d = ST_ALIVE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_EXPLODE: begin
                if (cnt_q == EXP_LAST) begin
                    state_d = (lives_q != 2'd0) ? ST_INVULN : ST_DEAD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DEAD: begin
                if (bus.spawn) begin
                    state_d = ST_INVULN;
                    lives_d = LIVES_INIT;
                    cnt_d   = 8'd0;
                end
            end
        endcase

        // Display outputs follow the next state so they line up with state_q.
        blink_d     = (state_d == ST_INVULN) && cnt_d[2];
        ef_d        = (state_d == ST_EXPLODE) ? cnt_d[3:2] : 2'd0;
        game_over_d = (state_d == ST_DEAD);
        alive_d     = (state_d == ST_ALIVE) || (state_d == ST_INVULN);
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q     <= ST_INVULN;
            cnt_q       <= 8'd0;
            lives_q     <= LIVES_INIT;
            armed_q     <= 1'b0;
            shell_hit_q <= 1'b0;
            blink_q     <= 1'b0;
            ef_q        <= 2'd0;
            game_over_q <= 1'b0;
            alive_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            armed_q     <= armed_d;
            shell_hit_q <= shell_hit_d;
            blink_q     <= blink_d;
            ef_q        <= ef_d;
            game_over_q <= game_over_d;
            alive_q     <= alive_d;
        end
    end

    assign bus.shell_hit     = shell_hit_q;
    assign bus.target_alive  = alive_q;
    assign bus.blink         = blink_q;
    assign bus.explode_frame = ef_q;
    assign bus.lives         = lives_q;
    assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_shell_target.sv
// tb/tb_shell_target.sv - scoreboard bench for shell_target
module tb_shell_target;

    logic clk;
    logic rst_n;

    shell_target_if bus ();

    shell_target dut (
        .frame_clk (clk),
        .Reset     (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {shell_hit, target_alive, blink, explode_frame, lives, game_over}
    typedef logic [7:0] exp_t;
    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {bus.shell_hit, bus.target_alive, bus.blink, bus.explode_frame, bus.lives, bus.game_over};
            n_checks++;
            if (g === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got hit=%b alive=%b blink=%b ef=%0d lives=%0d go=%b, want hit=%b alive=%b blink=%b ef=%0d lives=%0d go=%b",
                         nm, g[7], g[6], g[5], g[4:3], g[2:1], g[0], e[7], e[6], e[5], e[4:3], e[2:1], e[0]);
            end
        end
    end

    task automatic tick(input string nm, input logic hit, input logic alive, input logic blk,
                        input logic [1:0] ef, input logic [1:0] lv, input logic go);
        @(posedge clk);
        #1;
        exp_q.push_back({hit, alive, blk, ef, lv, go});
        name_q.push_back(nm);
    endtask

    task automatic t_inv(input string nm, input int k, input logic [1:0] lv, input logic hit);
        tick(nm, hit, 1'b1, k[2], 2'd0, lv, 1'b0);
    endtask

    task automatic t_alive(input string nm, input logic [1:0] lv);
        tick(nm, 1'b0, 1'b1, 1'b0, 2'd0, lv, 1'b0);
    endtask

    task automatic t_exp(input string nm, input int c, input logic [1:0] lv, input logic hit);
        tick(nm, hit, 1'b0, 1'b0, c[3:2], lv, 1'b0);
    endtask

    task automatic t_dead(input string nm);
        tick(nm, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    endtask

    task automatic t_reset(input string nm);
        tick(nm, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0);
    endtask

    task automatic run_invuln(input int k0, input logic [1:0] lv);
        for (int k = k0; k < 60; k++) t_inv("invuln", k, lv, 1'b0);
        t_alive("invuln_to_alive", lv);
    endtask

    task automatic run_explode(input int c0, input logic [1:0] lv);
        for (int c = c0; c < 16; c++) t_exp("explode", c, lv, 1'b0);
        if (lv != 2'd0) t_inv("explode_to_invuln", 0, lv, 1'b0);
        else            t_dead("explode_to_dead");
    endtask

    task automatic set_shell(input int x, input int y, input logic fly);
        bus.ShellX       = 10'(x);
        bus.ShellY       = 10'(y);
        bus.ShellS_X     = 10'd4;
        bus.ShellS_Y     = 10'd8;
        bus.shell_flying = fly;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, queue depth %0d, required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.TargetX = 10'd320;
        bus.TargetY = 10'd240;
        bus.TargetS = 10'd8;
        bus.spawn   = 1'b0;
        set_shell(100, 100, 1'b0);

        // Reset state, then a full invulnerability window with blinking.
        t_reset("reset_state");
        rst_n = 1'b1;
        run_invuln(1, 2'd3);

        // First hit from ALIVE, shell kept overlapping through the explosion.
        set_shell(325, 236, 1'b1);
        t_exp("first_hit", 0, 2'd2, 1'b1);
        run_explode(1, 2'd2);

        // Re-arm by landing, then absorb a hit during INVULN.
        bus.shell_flying = 1'b0;
        t_inv("rearm_drop", 1, 2'd2, 1'b0);
        bus.shell_flying = 1'b1;
        t_inv("invuln_absorb", 2, 2'd2, 1'b1);
        run_invuln(3, 2'd2);
        t_alive("alive_armed_hold", 2'd2);

        // Touching edges on both sides do not hit; one pixel closer does.
        bus.shell_flying = 1'b0;
        t_alive("rearm_alive", 2'd2);
        set_shell(308, 240, 1'b1);
        t_alive("edge_left_308", 2'd2);
        set_shell(332, 240, 1'b1);
        t_alive("edge_right_332", 2'd2);
        set_shell(309, 240, 1'b1);
        t_exp("edge_hit_309", 0, 2'd1, 1'b1);
        run_explode(1, 2'd1);
        run_invuln(1, 2'd1);

        // Third hit with spawn held during the explosion, ending in DEAD.
        bus.shell_flying = 1'b0;
        t_alive("rearm_third", 2'd1);
        bus.shell_flying = 1'b1;
        t_exp("third_hit", 0, 2'd0, 1'b1);
        bus.spawn = 1'b1;
        for (int c = 1; c < 5; c++) t_exp("spawn_ignored_explode", c, 2'd0, 1'b0);
        bus.spawn = 1'b0;
        run_explode(5, 2'd0);
        bus.shell_flying = 1'b0;
        t_dead("dead_hold");
        bus.spawn = 1'b1;
        t_inv("spawn_restart", 0, 2'd3, 1'b0);
        bus.spawn = 1'b0;
        run_invuln(1, 2'd3);

        // Reset in the middle of an explosion and while a hit is pending.
        bus.shell_flying = 1'b1;
        t_exp("pre_reset_hit", 0, 2'd2, 1'b1);
        for (int c = 1; c < 5; c++) t_exp("pre_reset_explode", c, 2'd2, 1'b0);
        rst_n = 1'b0;
        t_reset("reset_mid_explode");
        t_reset("reset_over_hit");
        rst_n = 1'b1;
        bus.shell_flying = 1'b0;
        t_inv("post_release_quiet", 1, 2'd3, 1'b0);
        bus.shell_flying = 1'b1;
        t_inv("post_release_hit", 2, 2'd3, 1'b1);
        t_inv("post_release_single", 3, 2'd3, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
